// File: rtl/prng_stream.sv
// prng_stream: seeded burst generator of NUM_OUT pseudo-random words per seed.
// The generator is picked per burst (xorshift or right-shift Galois LFSR).
// Output words are handed to the consumer under ready/valid backpressure.
module prng_stream #(
   parameter int                WIDTH        = 32,
   parameter int                NUM_OUT      = 16,
   parameter logic [WIDTH-1:0]  TAPS         = (WIDTH == 64) ? WIDTH'(64'hD800_0000_0000_0000)
                                                             : WIDTH'(64'h0000_0000_8020_0003),
   parameter logic [WIDTH-1:0]  DEFAULT_SEED = WIDTH'(1)
) (
   input  logic             clk1,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] seed,
   input  logic             mode,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] rand_num,
   output logic             last,
   output logic             busy
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } fsm_t;

   localparam int               CW       = 16;
   localparam logic [CW-1:0]    LAST_CNT = CW'(NUM_OUT - 1);

   fsm_t             fsm_q, fsm_d;
   logic [WIDTH-1:0] state_q, state_d;
   logic [CW-1:0]    count_q, count_d;
   logic             mode_q, mode_d;
   logic             at_last;

   // One generator step; m=0 selects xorshift, m=1 the Galois LFSR.
   function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] x, input logic m);
      logic [WIDTH-1:0] y;
      y = x;
      if (m) begin
         y = (x >> 1) ^ (x[0] ? TAPS : '0);
      end else if (WIDTH == 64) begin
         y = y ^ (y << 13);
         y = y ^ (y >> 7);
         y = y ^ (y << 17);
      end else begin
         y = y ^ (y << 13);
         y = y ^ (y >> 17);
         y = y ^ (y << 5);
      end
      return y;
   endfunction

   assign at_last = (count_q == LAST_CNT);

   // Next-state logic: seed acceptance in IDLE, stepping on each handshake in RUN.
   always_comb begin
      // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
      fsm_d   = fsm_q;
      state_d = state_q;
      count_d = count_q;
      mode_d  = mode_q;
      case (fsm_q)
         IDLE: begin
            if (in_valid) begin
               mode_d  = mode;
               state_d = step((seed == '0) ? DEFAULT_SEED : seed, mode);
               count_d = '0;
               fsm_d   = RUN;
            end
         end
         RUN: begin
            if (out_ready) begin
               state_d = step(state_q, mode_q);
               count_d = count_q + 1'b1;
               if (at_last) fsm_d = IDLE;
            end
         end
         default: fsm_d = IDLE;
      endcase
   end

   // State register with synchronous reset; rst overrides any seed strobe.
   always_ff @(posedge clk1) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (rst) begin
         fsm_q   <= IDLE;
         state_q <= '0;
         count_q <= '0;
         mode_q  <= 1'b0;
      end else begin
         fsm_q   <= fsm_d;
         state_q <= state_d;
         count_q <= count_d;
         mode_q  <= mode_d;
      end
   end

   // Outputs decode flops only, so no input reaches an output combinationally.
   assign out_valid = (fsm_q == RUN);
   assign busy      = (fsm_q == RUN);
   assign last      = (fsm_q == RUN) && at_last;
   assign rand_num  = state_q;

endmodule

// File: tb/tb_prng_stream.sv
// Directed bench for prng_stream: a cycle table on a NUM_OUT=3 instance
// plus a hand-written sequence on a NUM_OUT=1 instance.
module tb_prng_stream;

   logic        clk1 = 1'b0;
   logic        rst  = 1'b1;
   logic        in_valid = 1'b0, mode = 1'b0, out_ready = 1'b0;
   logic [31:0] seed = '0;
   logic        out_valid, last, busy;
   logic [31:0] rand_num;

   logic        in_valid_b = 1'b0, mode_b = 1'b0, out_ready_b = 1'b0;
   logic [31:0] seed_b = '0;
   logic        out_valid_b, last_b, busy_b;
   logic [31:0] rand_num_b;

   int checks = 0;
   int errors = 0;

   always #5 clk1 = ~clk1;

   prng_stream #(.WIDTH(32), .NUM_OUT(3)) dut (
      .clk1(clk1), .rst(rst), .in_valid(in_valid), .seed(seed), .mode(mode),
      .out_ready(out_ready), .out_valid(out_valid), .rand_num(rand_num),
      .last(last), .busy(busy)
   );

   prng_stream #(.WIDTH(32), .NUM_OUT(1)) dut1 (
      .clk1(clk1), .rst(rst), .in_valid(in_valid_b), .seed(seed_b), .mode(mode_b),
      .out_ready(out_ready_b), .out_valid(out_valid_b), .rand_num(rand_num_b),
      .last(last_b), .busy(busy_b)
   );

   typedef struct {
      logic        rst;
      logic        iv;
      logic [31:0] seed;
      logic        mode;
      logic        rdy;
      logic        ev;
      logic [31:0] er;
      logic        el;
      logic        eb;
      logic        cr;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", name, got, exp);
      end
   endtask

   task automatic add(input logic r, input logic iv, input logic [31:0] s, input logic m,
                      input logic rdy, input logic ev, input logic [31:0] er,
                      input logic el, input logic eb, input logic cr);
      vec_t v;
      v.rst = r; v.iv = iv; v.seed = s; v.mode = m; v.rdy = rdy;
      v.ev = ev; v.er = er; v.el = el; v.eb = eb; v.cr = cr;
      vecs.push_back(v);
   endtask

   // Drive dut1 for one cycle, then compare after the edge.
   task automatic cyc_b(input string name, input logic iv, input logic rdy,
                        input logic ev, input logic [31:0] er, input logic el,
                        input logic eb, input logic cr);
      in_valid_b  = iv;
      seed_b      = 32'd1;
      mode_b      = 1'b0;
      out_ready_b = rdy;
      @(posedge clk1);
      #1;
      check({name, " valid"}, {31'd0, out_valid_b}, {31'd0, ev});
      check({name, " last"},  {31'd0, last_b},      {31'd0, el});
      check({name, " busy"},  {31'd0, busy_b},      {31'd0, eb});
      if (cr) check({name, " rand"}, rand_num_b, er);
   endtask

   initial begin
      // Each row: inputs applied before an edge, outputs expected just after it.
      //    rst iv seed   md rdy  ev er            el eb cr
      // reset state
      add(1, 0, 32'd0, 0, 0,   0, 32'h0,        0, 0, 1);
      // xorshift32 seed=1, ready held high
      add(0, 1, 32'd1, 0, 1,   1, 32'h00042021, 0, 1, 1);
      add(0, 0, 32'd0, 0, 1,   1, 32'h04080601, 0, 1, 1);
      add(0, 0, 32'd0, 0, 1,   1, 32'h9DCCA8C5, 1, 1, 1);
      add(0, 0, 32'd0, 0, 1,   0, 32'h0,        0, 0, 0);
      // Galois seed=1; mode toggled mid-burst must not matter
      add(0, 1, 32'd1, 1, 1,   1, 32'h80200003, 0, 1, 1);
      add(0, 0, 32'd7, 0, 1,   1, 32'hC0300002, 0, 1, 1);
      add(0, 0, 32'd0, 0, 1,   1, 32'h60180001, 1, 1, 1);
      add(0, 0, 32'd0, 0, 1,   0, 32'h0,        0, 0, 0);
      // zero seed behaves as seed=1
      add(0, 1, 32'd0, 0, 1,   1, 32'h00042021, 0, 1, 1);
      add(0, 0, 32'd0, 0, 1,   1, 32'h04080601, 0, 1, 1);
      add(0, 0, 32'd0, 0, 1,   1, 32'h9DCCA8C5, 1, 1, 1);
      add(0, 0, 32'd0, 0, 1,   0, 32'h0,        0, 0, 0);
      // backpressure: ready 1,0,0,1,0,1
      add(0, 1, 32'd1, 0, 0,   1, 32'h00042021, 0, 1, 1);
      add(0, 0, 32'd0, 0, 1,   1, 32'h04080601, 0, 1, 1);
      add(0, 0, 32'd0, 0, 0,   1, 32'h04080601, 0, 1, 1);
      add(0, 0, 32'd0, 0, 0,   1, 32'h04080601, 0, 1, 1);
      add(0, 0, 32'd0, 0, 1,   1, 32'h9DCCA8C5, 1, 1, 1);
      add(0, 0, 32'd0, 0, 0,   1, 32'h9DCCA8C5, 1, 1, 1);
      add(0, 0, 32'd0, 0, 1,   0, 32'h0,        0, 0, 0);
      // seed strobes in RUN and in the final-handshake cycle are ignored
      add(0, 1, 32'd1, 0, 1,   1, 32'h00042021, 0, 1, 1);
      add(0, 1, 32'd5, 0, 1,   1, 32'h04080601, 0, 1, 1);
      add(0, 0, 32'd0, 0, 1,   1, 32'h9DCCA8C5, 1, 1, 1);
      add(0, 1, 32'd5, 0, 1,   0, 32'h0,        0, 0, 0);
      add(0, 0, 32'd0, 0, 1,   0, 32'h0,        0, 0, 0);
      // reset mid-burst, then reset winning over a seed strobe
      add(0, 1, 32'd1, 0, 1,   1, 32'h00042021, 0, 1, 1);
      add(0, 0, 32'd0, 0, 1,   1, 32'h04080601, 0, 1, 1);
      add(1, 0, 32'd0, 0, 1,   0, 32'h0,        0, 0, 1);
      add(1, 1, 32'd9, 1, 1,   0, 32'h0,        0, 0, 1);
      add(0, 1, 32'd1, 0, 1,   1, 32'h00042021, 0, 1, 1);
      add(0, 0, 32'd0, 0, 1,   1, 32'h04080601, 0, 1, 1);
      add(0, 0, 32'd0, 0, 1,   1, 32'h9DCCA8C5, 1, 1, 1);
      add(0, 0, 32'd0, 0, 1,   0, 32'h0,        0, 0, 0);

      foreach (vecs[i]) begin
         rst       = vecs[i].rst;
         in_valid  = vecs[i].iv;
         seed      = vecs[i].seed;
         mode      = vecs[i].mode;
         out_ready = vecs[i].rdy;
         @(posedge clk1);
         #1;
         check($sformatf("v%0d valid", i), {31'd0, out_valid}, {31'd0, vecs[i].ev});
         check($sformatf("v%0d last", i),  {31'd0, last},      {31'd0, vecs[i].el});
         check($sformatf("v%0d busy", i),  {31'd0, busy},      {31'd0, vecs[i].eb});
         if (vecs[i].cr) check($sformatf("v%0d rand", i), rand_num, vecs[i].er);
      end

      // NUM_OUT=1 instance: single word carries last, then immediate re-seed.
      rst = 1'b1;
      cyc_b("n1 reset", 0, 0, 0, 32'h0, 0, 0, 1);
      rst = 1'b0;
      cyc_b("n1 accept", 1, 0, 1, 32'h00042021, 1, 1, 1);
      cyc_b("n1 stall",  0, 0, 1, 32'h00042021, 1, 1, 1);
      cyc_b("n1 final",  1, 1, 0, 32'h0, 0, 0, 0);
      cyc_b("n1 idle",   0, 0, 0, 32'h0, 0, 0, 0);
      cyc_b("n1 reseed", 1, 1, 1, 32'h00042021, 1, 1, 1);
      cyc_b("n1 done",   0, 1, 0, 32'h0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/prng_stream.md
# prng_stream

Parametrised pseudo-random stream generator, successor to the single-seed `prng` block. It accepts a seed through a valid strobe and emits a burst of `NUM_OUT` pseudo-random words per seed under ready/valid backpressure. The generator is selected per burst as xorshift or Galois LFSR. It runs in a single clock domain and sits downstream of the seed source, feeding any consumer that can stall.

## Interface
Parameters:
- `WIDTH`, 32, word width of the state and `rand_num`; legal values are 32 and 64 only.
- `NUM_OUT`, 16, number of words per burst; legal range is 1..65535.
- `TAPS`, 32'h8020_0003, Galois feedback mask for right-shift LFSR mode; the WIDTH=64 default is 64'hD800_0000_0000_0000.
- `DEFAULT_SEED`, 1, nonzero value that replaces a zero seed.

Ports:
- `clk1`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  seed strobe.
- `seed`  in  WIDTH  seed word, sampled when the seed is accepted.
- `mode`  in  1  generator select, sampled with the seed: 0 = xorshift, 1 = Galois LFSR.
- `out_ready`  in  1  consumer ready.
- `out_valid`  out  1  `rand_num` is valid.
- `rand_num`  out  WIDTH  generated word.
- `last`  out  1  high with the final word of a burst.
- `busy`  out  1  high while a burst is in progress; seeds are refused.

## Operation
- FSM states are IDLE and RUN.
- Acceptance: in IDLE, `in_valid`=1 accepts the seed. `s0` = (`seed`==0 ? `DEFAULT_SEED` : `seed`). The block latches `mode`, loads state := step(`s0`), clears the count to 0 and moves to RUN.
- `in_valid` is ignored in RUN. It is also ignored in the cycle of the final handshake, because the FSM is still in RUN during that cycle.
- RUN behaviour:
  - `out_valid`=1 and `rand_num`=state.
  - On handshake (`out_valid`&`out_ready`): state := step(state) and count += 1.
  - If count==`NUM_OUT`-1 at the handshake, the FSM goes to IDLE.
- xorshift step, WIDTH=32, executed in order: x ^= x<<13; x ^= x>>17; x ^= x<<5.
- xorshift step, WIDTH=64, executed in order: x ^= x<<13; x ^= x>>7; x ^= x<<17.
- Galois step: x = (x>>1) ^ (x[0] ? `TAPS` : 0).
- All arithmetic is modulo 2^WIDTH. Shifts are logical, and bits shifted out are dropped.
- Zero state is unreachable in both modes, given a nonzero `DEFAULT_SEED` and a maximal `TAPS`.
- `last` = RUN & (count==`NUM_OUT`-1). For `NUM_OUT`=1, `last` is high on the only word.
- `busy` = (FSM==RUN).
- Backpressure: while `out_valid`=1 and `out_ready`=0, `rand_num`, `last` and the count hold stable.
- `mode` and `seed` changes during RUN have no effect.

## Timing
- Reset values: `out_valid`=0, `rand_num`=0, `last`=0, `busy`=0. Internal state, count and latched mode are all 0, and the FSM is in IDLE.
- Reset takes effect on the rising edge where `rst`=1. Asserted mid-burst, it aborts the burst with no further words, and all outputs are at reset values after that edge. `rst` has priority over `in_valid`.
- Latency: seed accepted at edge N; `out_valid`=1 with the first word from edge N (visible in cycle N+1).
- Throughput: one word per cycle while `out_ready`=1. A burst with `out_ready` held high takes exactly `NUM_OUT` cycles in RUN.
- After the final handshake at edge M, `out_valid`=0 and `busy`=0 from M. The earliest next seed acceptance is edge M+1. The minimum seed-to-seed interval is therefore `NUM_OUT`+1 cycles.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- xorshift32, seed=1, mode=0, `out_ready`=1, `NUM_OUT`=3 → `rand_num` = 0x00042021, 0x04080601, 0x9DCCA8C5 on consecutive cycles; `last` is high only on the third; `busy` then falls.
- Galois, seed=1, mode=1, default `TAPS` → first two words are 0x80200003, then 0xC0300002.
- seed=0, mode=0 → output is identical to the seed=1 run (0x00042021 first).
- Backpressure: `out_ready` toggles 1,0,0,1,… during a xorshift seed=1 burst → word 2 (0x04080601) holds for 3 cycles; no word is skipped or duplicated; total handshakes equal `NUM_OUT`.
- `in_valid` pulses with seed=5 during RUN and in the final-handshake cycle → both pulses are ignored, and the burst stays on the seed=1 sequence.
- `rst`=1 after 2 words of a 16-word burst → next cycle `out_valid`=0, `busy`=0, `rand_num`=0. A new seed=1 then restarts at 0x00042021.
